// File: rtl/picomem_arb_2m.sv
// picomem_arb_2m: two-master arbiter in front of a single PicoMem-style slave.
// Master 0 is the CPU, master 1 a loader/DMA. One IDLE arbitration cycle
// precedes every grant; the granted master is mirrored onto the slave port.
// Optional feature macro: PICOMEM_ARB_RR_EN selects round-robin on
// simultaneous requests; when undefined, m0 has fixed priority.
module picomem_arb_2m #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic [1:0]        arb_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Winner when both masters request in the same IDLE cycle (1 = m1)
  logic pick_m1_c;

`ifdef PICOMEM_ARB_RR_EN
  // Round-robin pointer: 1 when m1 held the most recent grant
  logic last_m1;

  // Pointer update on every grant taken out of IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_m1 <= 1'b1;
    end else if ((state == IDLE) && (m0_valid || m1_valid)) begin
      last_m1 <= (state_nxt == GNT1);
    end
  end

  assign pick_m1_c = ~last_m1;
`else
  assign pick_m1_c = 1'b0;
`endif

  // State register; reset drops any transaction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and slave/master muxing
  always_comb begin
    state_nxt = state;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = 32'h0;
    s_wstrb   = 4'h0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    arb_grant = 2'b00;

    unique case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = pick_m1_c ? GNT1 : GNT0;
        end else if (m0_valid) begin
          state_nxt = GNT0;
        end else if (m1_valid) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        s_valid   = m0_valid;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_wstrb   = m0_wstrb;
        m0_ready  = s_ready;
        arb_grant = 2'b01;
        // Completion or master abort both end the grant
        if (s_ready || !m0_valid) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        s_valid   = m1_valid;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_wstrb   = m1_wstrb;
        m1_ready  = s_ready;
        arb_grant = 2'b10;
        if (s_ready || !m1_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ready
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_picomem_arb_2m.sv
// Bench for picomem_arb_2m: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level model of the arbiter.
// Honours PICOMEM_ARB_RR_EN in the same way as the design.
module tb_picomem_arb_2m;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              m0_valid = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [31:0]       m0_wdata = 32'h0;
  logic [3:0]        m0_wstrb = 4'h0;
  logic              m0_ready;
  logic [31:0]       m0_rdata;
  logic              m1_valid = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [31:0]       m1_wdata = 32'h0;
  logic [3:0]        m1_wstrb = 4'h0;
  logic              m1_ready;
  logic [31:0]       m1_rdata;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_ready = 1'b0;
  logic [31:0]       s_rdata = 32'h0;
  logic [1:0]        arb_grant;

  picomem_arb_2m #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .arb_grant(arb_grant)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: who owns the slave (-1 nobody, else master index) and who won last
  int owner   = -1;
  int last_gn = 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model reaction to a rising edge, using the inputs held across it
  task automatic model_edge();
    if (!resetn) begin
      owner   = -1;
      last_gn = 1;
    end else if (owner < 0) begin
      if (m0_valid && m1_valid) begin
`ifdef PICOMEM_ARB_RR_EN
        owner = 1 - last_gn;
`else
        owner = 0;
`endif
      end else if (m0_valid) begin
        owner = 0;
      end else if (m1_valid) begin
        owner = 1;
      end
      if (owner >= 0) last_gn = owner;
    end else begin
      if (s_ready || !(owner == 0 ? m0_valid : m1_valid)) owner = -1;
    end
  endtask

  // Compare every output against what the model says the slave port should show
  task automatic check_outputs(input string tag);
    logic              e_sv;
    logic [ADDR_W-1:0] e_sa;
    logic [31:0]       e_sd;
    logic [3:0]        e_ss;
    logic [1:0]        e_g;
    e_sv = 1'b0; e_sa = '0; e_sd = 32'h0; e_ss = 4'h0; e_g = 2'b00;
    if (owner == 0) begin
      e_sv = m0_valid; e_sa = m0_addr; e_sd = m0_wdata; e_ss = m0_wstrb; e_g = 2'b01;
    end else if (owner == 1) begin
      e_sv = m1_valid; e_sa = m1_addr; e_sd = m1_wdata; e_ss = m1_wstrb; e_g = 2'b10;
    end
    check({tag, ".grant"},   64'(arb_grant), 64'(e_g));
    check({tag, ".s_valid"}, 64'(s_valid),   64'(e_sv));
    check({tag, ".s_addr"},  64'(s_addr),    64'(e_sa));
    check({tag, ".s_wdata"}, 64'(s_wdata),   64'(e_sd));
    check({tag, ".s_wstrb"}, 64'(s_wstrb),   64'(e_ss));
    check({tag, ".m0_rdy"},  64'(m0_ready),  64'((owner == 0) && s_ready));
    check({tag, ".m1_rdy"},  64'(m1_ready),  64'((owner == 1) && s_ready));
    check({tag, ".m0_rd"},   64'(m0_rdata),  64'(s_rdata));
    check({tag, ".m1_rd"},   64'(m1_rdata),  64'(s_rdata));
  endtask

  // Inputs are applied at a falling edge; check, then cross one rising edge
  task automatic step(input string tag);
    #1 check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic reset_now();
    resetn  = 1'b0;
    owner   = -1;
    last_gn = 1;
  endtask

  int exp_seq [4];
  logic [1:0] grant_seen;

  initial begin
`ifdef PICOMEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    // Reset state
    @(negedge clk);
    step("rst");
    step("rst");
    resetn = 1'b1;

    // m0 read alone
    m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
    step("rd_arb");
    step("rd_wait");
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1 check("rd_m0_rdy", 64'(m0_ready), 64'd1);
    check("rd_m0_rdata", 64'(m0_rdata), 64'hDEAD_BEEF);
    check("rd_m1_rdy", 64'(m1_ready), 64'd0);
    step("rd_done");
    m0_valid = 1'b0; s_ready = 1'b0;
    step("rd_idle");

    // m1 write alone
    m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    step("wr_arb");
    s_ready = 1'b1;
    #1 check("wr_grant", 64'(arb_grant), 64'h2);
    check("wr_s_addr", 64'(s_addr), 64'h100);
    check("wr_s_wdata", 64'(s_wdata), 64'h1234_5678);
    step("wr_done");
    m1_valid = 1'b0; s_ready = 1'b0;
    #1 check("wr_m1_rdy_gone", 64'(m1_ready), 64'd0);
    step("wr_idle");

    // m0 aborts before the slave answers
    m0_valid = 1'b1; m0_addr = 32'h0000_0040;
    step("ab_arb");
    step("ab_gnt");
    m0_valid = 1'b0;
    step("ab_drop");
    #1 check("ab_s_valid", 64'(s_valid), 64'd0);
    check("ab_grant", 64'(arb_grant), 64'd0);
    step("ab_idle");

    // Reset while m1 is waiting on the slave
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    step("rg_arb");
    step("rg_gnt1");
    m0_valid = 1'b1; m0_addr = 32'h0000_0300;
    reset_now();
    #1 check("rg_s_valid", 64'(s_valid), 64'd0);
    check("rg_m1_rdy", 64'(m1_ready), 64'd0);
    check("rg_grant", 64'(arb_grant), 64'd0);
    step("rg_inrst");
    resetn = 1'b1;

    // Both held valid for four transactions
    for (int t = 0; t < 4; t++) begin
      step("both_arb");
      grant_seen = arb_grant;
      check("both_order", 64'(grant_seen), 64'(exp_seq[t] == 0 ? 2'b01 : 2'b10));
      s_ready = 1'b1; s_rdata = $urandom;
      step("both_done");
      s_ready = 1'b0;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    step("both_idle");

    // Random traffic, occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) m0_valid = ~m0_valid;
      if ($urandom_range(0, 3) == 0) m1_valid = ~m1_valid;
      m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 79) == 0) reset_now();
      step("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
